// File: rtl/axi_stream_packet_arbiter.sv
// Packet-level round-robin arbiter for an AXI-Stream M2S mux.
// Picks one upstream source, holds the mux select (addr) until the
// downstream tlast handshake, then inserts one idle cycle before the
// next pick. Optional watchdog (macro AXIS_PACKET_ARB_WATCHDOG_EN)
// releases a lock that has stalled for TIMEOUT cycles.
module axi_stream_packet_arbiter #(
   parameter int NUM     = 8,
   parameter int NSIZE   = (NUM <= 2) ? 1 : (NUM <= 4) ? 2 : (NUM <= 8) ? 3 : (NUM <= 16) ? 4 : 5,
   parameter int TIMEOUT = 1024
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             aclken,
   input  logic [NUM-1:0]   req,
   input  logic             m_tvalid,
   input  logic             m_tready,
   input  logic             m_tlast,
   output logic [NSIZE-1:0] addr,
   output logic             locked,
   output logic [NUM-1:0]   grant,
   output logic             timeout
);

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t           state;
   logic [NSIZE-1:0] last;
   logic [NSIZE-1:0] pick;
   logic             beat;
   logic             eop;
   logic             rel;

   assign beat = m_tvalid & m_tready;
   assign eop  = beat & m_tlast;

   // Circular priority search starting just above the previously granted
   // index: the lowest set bit above 'from' wins, otherwise wrap around to
   // the lowest set bit overall.
   function automatic logic [NSIZE-1:0] next_pick(input logic [NUM-1:0] r,
                                                  input logic [NSIZE-1:0] from);
      logic [NSIZE-1:0] sel_hi;
      logic [NSIZE-1:0] sel_any;
      logic             found_hi;
      sel_hi   = '0;
      sel_any  = '0;
      found_hi = 1'b0;
      for (int i = NUM - 1; i >= 0; i--) begin
         if (r[i]) begin
            sel_any = NSIZE'(i);
         end
         if (r[i] && (i > int'(from))) begin
            sel_hi   = NSIZE'(i);
            found_hi = 1'b1;
         end
      end
      return found_hi ? sel_hi : sel_any;
   endfunction

   // Candidate source for the next grant, evaluated every cycle.
   always_comb begin
      pick = next_pick(req, last);
   end

`ifdef AXIS_PACKET_ARB_WATCHDOG_EN
   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [WD_W-1:0] wd_cnt;
   logic            wd_expire;
   logic            timeout_q;

   // A locked packet that has gone TIMEOUT cycles without any beat is dropped.
   assign wd_expire = (state == LOCK) && !beat && (wd_cnt == WD_W'(TIMEOUT - 1));
   assign rel       = eop | wd_expire;
   assign timeout   = timeout_q;

   // Stall counter: runs only while locked and stalled, zero otherwise.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
      end else if (aclken) begin
         timeout_q <= wd_expire;
         if (state == IDLE || beat || wd_expire) begin
            wd_cnt <= '0;
         end else begin
            wd_cnt <= wd_cnt + 1'b1;
         end
      end
   end
`else
   assign rel = eop;
   // Tied low; TIMEOUT has no effect without the watchdog.
   assign timeout = (TIMEOUT < 0);
`endif

   // Two-state packet lock FSM with registered select/lock/grant outputs.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state  <= IDLE;
         addr   <= '0;
         locked <= 1'b0;
         grant  <= '0;
         last   <= NSIZE'(NUM - 1);
      end else if (aclken) begin
         case (state)
            IDLE: begin
               if (|req) begin
                  addr   <= pick;
                  locked <= 1'b1;
                  grant  <= NUM'(1) << pick;
                  state  <= LOCK;
               end
            end
            LOCK: begin
               if (rel) begin
                  last   <= addr;
                  locked <= 1'b0;
                  grant  <= '0;
                  state  <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_stream_packet_arbiter.sv
// Self-checking bench for axi_stream_packet_arbiter (NUM=8, TIMEOUT=16).
module tb_axi_stream_packet_arbiter;

   localparam int NUM        = 8;
   localparam int TIMEOUT_TB = 16;
`ifdef AXIS_PACKET_ARB_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic           aclk;
   logic           aresetn;
   logic           aclken;
   logic [NUM-1:0] req;
   logic           m_tvalid;
   logic           m_tready;
   logic           m_tlast;
   logic [2:0]     addr;
   logic           locked;
   logic [NUM-1:0] grant;
   logic           timeout;

   axi_stream_packet_arbiter #(
      .NUM(NUM),
      .TIMEOUT(TIMEOUT_TB)
   ) dut (
      .aclk(aclk),
      .aresetn(aresetn),
      .aclken(aclken),
      .req(req),
      .m_tvalid(m_tvalid),
      .m_tready(m_tready),
      .m_tlast(m_tlast),
      .addr(addr),
      .locked(locked),
      .grant(grant),
      .timeout(timeout)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: who owns the mux, who was served last, how
   // long the current owner has stalled.
   bit mdl_locked;
   int mdl_addr;
   int mdl_last;
   int mdl_wd;
   bit mdl_to;

   typedef struct {
      logic [7:0] req;
      logic       hs;
      logic       lst;
      logic       en;
      logic       exp_locked;
      logic [2:0] exp_addr;
   } vec_t;

   vec_t vt[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mdl_locked = 1'b0;
      mdl_addr   = 0;
      mdl_last   = NUM - 1;
      mdl_wd     = 0;
      mdl_to     = 1'b0;
   endtask

   task automatic check_model();
      check("addr", 32'(addr), 32'(mdl_addr));
      check("locked", 32'(locked), 32'(mdl_locked));
      check("grant", 32'(grant), mdl_locked ? (32'd1 << mdl_addr) : 32'd0);
      check("timeout", 32'(timeout), 32'(mdl_to));
   endtask

   // Advance one clock: predict from the inputs the DUT will sample, then compare.
   task automatic tick();
      bit hs;
      hs = m_tvalid && m_tready;
      if (aclken) begin
         mdl_to = 1'b0;
         if (!mdl_locked) begin
            if (req != '0) begin
               for (int k = 1; k <= NUM; k++) begin
                  int c;
                  c = (mdl_last + k) % NUM;
                  if (req[c]) begin
                     mdl_addr = c;
                     break;
                  end
               end
               mdl_locked = 1'b1;
               mdl_wd     = 0;
            end
         end else if (hs && m_tlast) begin
            mdl_last   = mdl_addr;
            mdl_locked = 1'b0;
         end else if (WD && !hs && (mdl_wd == TIMEOUT_TB - 1)) begin
            mdl_last   = mdl_addr;
            mdl_locked = 1'b0;
            mdl_to     = 1'b1;
         end else if (hs) begin
            mdl_wd = 0;
         end else begin
            mdl_wd++;
         end
      end
      @(posedge aclk);
      #1;
      check_model();
   endtask

   task automatic idle_bus();
      m_tvalid = 1'b0;
      m_tready = 1'b0;
      m_tlast  = 1'b0;
   endtask

   // Asynchronous reset: outputs must clear without waiting for a clock.
   task automatic do_reset();
      aresetn = 1'b0;
      #1;
      check("rst_addr", 32'(addr), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      model_reset();
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
   endtask

   initial begin
      aresetn = 1'b0;
      aclken  = 1'b1;
      req     = '0;
      idle_bus();
      model_reset();
      #12;
      do_reset();

      // Table: alternating 0/2, aclken hold, req drop while locked, idle hold.
      vt[0]  = '{8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
      vt[1]  = '{8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
      vt[2]  = '{8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2};
      vt[3]  = '{8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2};
      vt[4]  = '{8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
      vt[5]  = '{8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
      vt[6]  = '{8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2};
      vt[7]  = '{8'h05, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2};
      vt[8]  = '{8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2};
      vt[9]  = '{8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2};
      vt[10] = '{8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
      vt[11] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
      vt[12] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0};
      vt[13] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
      vt[14] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
      vt[15] = '{8'h84, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2};

      for (int i = 0; i < 16; i++) begin
         req      = vt[i].req;
         m_tvalid = vt[i].hs;
         m_tready = vt[i].hs;
         m_tlast  = vt[i].lst;
         aclken   = vt[i].en;
         tick();
         check($sformatf("vec%0d_locked", i), 32'(locked), 32'(vt[i].exp_locked));
         check($sformatf("vec%0d_addr", i), 32'(addr), 32'(vt[i].exp_addr));
      end
      aclken = 1'b1;
      idle_bus();

      // All sources requesting, 3-beat packets: addr walks 0..7 then 0.
      do_reset();
      req = 8'hFF;
      for (int p = 0; p < 9; p++) begin
         idle_bus();
         tick();
         check($sformatf("rr_addr%0d", p), 32'(addr), 32'(p % NUM));
         check("rr_locked", 32'(locked), 32'd1);
         for (int b = 0; b < 3; b++) begin
            m_tvalid = 1'b1;
            m_tready = 1'b1;
            m_tlast  = (b == 2);
            tick();
            check("rr_lock_hold", 32'(locked), (b == 2) ? 32'd0 : 32'd1);
         end
      end
      idle_bus();

      // Source 3 drops its request mid-packet while 5 arrives.
      do_reset();
      req = 8'h08;
      tick();
      check("drop_addr3", 32'(addr), 32'd3);
      req      = 8'h20;
      m_tvalid = 1'b1;
      m_tready = 1'b1;
      for (int b = 0; b < 2; b++) begin
         tick();
         check("drop_hold3", 32'(addr), 32'd3);
         check("drop_lock", 32'(locked), 32'd1);
      end
      m_tlast = 1'b1;
      tick();
      check("drop_release", 32'(locked), 32'd0);
      idle_bus();
      tick();
      check("drop_next5", 32'(addr), 32'd5);

      // Reset mid-packet from source 6, then re-grant 6.
      do_reset();
      req = 8'h40;
      tick();
      check("rst6_addr", 32'(addr), 32'd6);
      m_tvalid = 1'b1;
      m_tready = 1'b1;
      tick();
      idle_bus();
      do_reset();
      tick();
      check("rst6_regrant", 32'(addr), 32'd6);
      check("rst6_locked", 32'(locked), 32'd1);

`ifdef AXIS_PACKET_ARB_WATCHDOG_EN
      // Stalled downstream: watchdog releases on the 16th locked cycle.
      do_reset();
      req = 8'h0A;
      tick();
      check("wd_addr1", 32'(addr), 32'd1);
      m_tvalid = 1'b1;
      m_tready = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         tick();
         check("wd_timeout", 32'(timeout), (c == 16) ? 32'd1 : 32'd0);
         check("wd_locked", 32'(locked), (c == 16) ? 32'd0 : 32'd1);
      end
      idle_bus();
      tick();
      check("wd_pulse_end", 32'(timeout), 32'd0);
      check("wd_next3", 32'(addr), 32'd3);
`endif

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         if ((n % 500) == 499) begin
            do_reset();
         end
         if ($urandom_range(0, 3) == 0) begin
            req = NUM'($urandom);
         end
         m_tvalid = ($urandom_range(0, 3) != 0);
         m_tready = ($urandom_range(0, 3) != 0);
         m_tlast  = ($urandom_range(0, 2) == 0);
         aclken   = ($urandom_range(0, 7) != 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
